keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter ROW_CYCLES, default 131072, clk cycles each row is driven; legal range >= 4.
REQ-002 Parameter DEBOUNCE_SCANS, default 4, consecutive identical full scans needed to accept a press or a release; legal range >= 1.
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 col  input  4  keypad column lines, active-low (pulled up externally), asynchronous to clk.
REQ-006 row  output  4  keypad row drive, active-low, exactly one bit low at any time.
REQ-007 clear  input  1  synchronous request to zero val.
REQ-008 val  output  16  last four accepted key codes, newest in [3:0].
REQ-009 key_valid  output  1  one-cycle pulse per accepted press.
REQ-010 key_code  output  4  code of the most recently accepted key.
REQ-011 key_held  output  1  high while an accepted key remains pressed.

Function
REQ-012 col SHALL pass through a 2-flop synchronizer before any use.
REQ-013 A row counter SHALL advance row index r = 0,1,2,3,0,... every ROW_CYCLES cycles; row = ~(4'b0001 << r).
REQ-014 Synchronized col SHALL be sampled once per row, on the last cycle of that row's period.
REQ-015 Key code SHALL be {r[1:0], c[1:0]}, where c is the column index with the sampled col bit low.
REQ-016 At the end of each full scan (after the row-3 sample), the scan result SHALL be NONE (no low bit seen), SINGLE(k) (exactly one low bit across all 4 rows), or MULTI (two or more).
REQ-017 FSM states: IDLE, DEB_PRESS, PRESSED, DEB_RELEASE; FSM and debounce count update only at scan end.
REQ-018 IDLE: SINGLE(k) -> DEB_PRESS with candidate k, count=1. NONE or MULTI -> stay in IDLE.
REQ-019 DEB_PRESS: SINGLE(same k) -> count+1. Any other result -> IDLE.
REQ-020 On reaching count == DEBOUNCE_SCANS, the FSM SHALL go to PRESSED and accept k. With DEBOUNCE_SCANS=1, acceptance happens directly from IDLE.
REQ-021 Accept actions: key_valid=1 for exactly one cycle, the cycle after the scan-end sample; key_code<=k and val<={val[11:0],k} in that same cycle.
REQ-022 PRESSED: key_held=1. NONE -> DEB_RELEASE with count=1. SINGLE or MULTI -> stay.
REQ-023 DEB_RELEASE: key_held stays 1. NONE -> count+1; reaching DEBOUNCE_SCANS -> IDLE and key_held=0. SINGLE or MULTI -> PRESSED.
REQ-024 A held key SHALL produce no repeat pulses; a new key_valid requires passing through IDLE.
REQ-025 clear SHALL set val=0 on the next edge. If clear coincides with an accept, clear wins for val (val=0), while key_valid and key_code still update.
REQ-026 Row and cycle counters SHALL wrap freely; scanning never stops, including during clear.

Reset
REQ-027 reset_n low SHALL immediately force: row=4'b1110, val=0, key_code=0, key_valid=0, key_held=0, FSM=IDLE, all counters and synchronizer flops =0.
REQ-028 Reset mid-operation SHALL discard any pending candidate; after release, scanning restarts at row 0, cycle 0.

Verification (bench uses ROW_CYCLES=4, DEBOUNCE_SCANS=2; keypad model pulls col[c] low while row[r] is low for each closed key)
REQ-029 Reset: assert reset_n=0 mid-cycle -> row=1110, val=0000, key_valid=0, key_held=0 without waiting for a clk edge.
REQ-030 Close key r=1,c=2 for 4 scans, then open -> exactly one key_valid pulse, key_code=6, val=0006; key_held falls 2 scans after opening.
REQ-031 Bounce: close key r=0,c=1 for 1 scan only -> no key_valid, val unchanged, FSM back in IDLE.
REQ-032 Press and release codes 1,2,3,4 in sequence (r0c1, r0c2, r0c3, r1c0) -> four pulses, val=1234; then a fifth key F (r3c3) -> val=234F.
REQ-033 Close r0c0 and r2c1 together for 4 scans -> no key_valid, key_held=0. From PRESSED on key 5, adding a second key -> no pulse, key_held stays 1.
REQ-034 Assert clear in the accept cycle of key 7 with val=1234 -> val=0000, key_code=7, one key_valid pulse; reset_n low while PRESSED -> key_held=0 and val=0000 immediately.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, debounces whole-scan
// results, and pushes accepted key codes into a 16-bit history register.
module keypad_scanner #(
    parameter int unsigned ROW_CYCLES     = 131072,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    input  logic        clear,
    output logic [15:0] val,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held
);

    localparam int unsigned CW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(ROW_CYCLES - 1);
    localparam logic [DW-1:0] DEB_N    = DW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;
    typedef enum logic [1:0] {SCAN_NONE, SCAN_SINGLE, SCAN_MULTI} scan_t;

    logic [3:0]    col_s1, col_s2;
    logic [CW-1:0] cyc;
    logic [1:0]    r;
    scan_t         acc;
    logic [3:0]    acc_code;
    state_t        state;
    logic [DW-1:0] cnt;
    logic [3:0]    cand;

    logic          sample, scan_end;
    logic [2:0]    nlow;
    logic [1:0]    cidx;
    scan_t         cur_res;
    logic [3:0]    cur_code;
    logic          accept, released;

    always_comb row = ~(4'b0001 << r);

    // Fold this row's sample into the running scan result so the scan-end
    // decision already includes the row-3 sample taken on the same edge.
    always_comb begin
        nlow = '0;
        cidx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!col_s2[i]) begin
                nlow = nlow + 3'd1;
                cidx = 2'(i);
            end
        end
        sample   = (cyc == CYC_LAST);
        scan_end = sample && (r == 2'd3);
        cur_res  = acc;
        cur_code = acc_code;
        if (nlow == 3'd1 && acc == SCAN_NONE) begin
            cur_res  = SCAN_SINGLE;
            cur_code = {r, cidx};
        end else if (nlow != 3'd0) begin
            cur_res = SCAN_MULTI;
        end
        accept = scan_end && (cur_res == SCAN_SINGLE) &&
                 ((state == IDLE && DEB_N == DW'(1)) ||
                  (state == DEB_PRESS && cur_code == cand && cnt + DW'(1) == DEB_N));
        released = scan_end && (cur_res == SCAN_NONE) &&
                   ((state == PRESSED && DEB_N == DW'(1)) ||
                    (state == DEB_RELEASE && cnt + DW'(1) == DEB_N));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_s1    <= '0;
            col_s2    <= '0;
            cyc       <= '0;
            r         <= '0;
            acc       <= SCAN_NONE;
            acc_code  <= '0;
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            val       <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
        end else begin
            col_s1    <= col;
            col_s2    <= col_s1;
            key_valid <= accept;

            if (sample) begin
                cyc <= '0;
                r   <= r + 2'd1;
            end else begin
                cyc <= cyc + CW'(1);
            end

            if (scan_end) begin
                acc      <= SCAN_NONE;
                acc_code <= '0;
            end else if (sample) begin
                acc      <= cur_res;
                acc_code <= cur_code;
            end

            if (accept) begin
                state    <= PRESSED;
                key_code <= cur_code;
                key_held <= 1'b1;
            end else if (released) begin
                state    <= IDLE;
                key_held <= 1'b0;
            end else if (scan_end) begin
                case (state)
                    IDLE: begin
                        if (cur_res == SCAN_SINGLE) begin
                            state <= DEB_PRESS;
                            cand  <= cur_code;
                            cnt   <= DW'(1);
                        end
                    end
                    DEB_PRESS: begin
                        if (cur_res == SCAN_SINGLE && cur_code == cand)
                            cnt <= cnt + DW'(1);
                        else
                            state <= IDLE;
                    end
                    PRESSED: begin
                        if (cur_res == SCAN_NONE) begin
                            state <= DEB_RELEASE;
                            cnt   <= DW'(1);
                        end
                    end
                    DEB_RELEASE: begin
                        if (cur_res == SCAN_NONE)
                            cnt <= cnt + DW'(1);
                        else
                            state <= PRESSED;
                    end
                    default: state <= IDLE;
                endcase
            end

            // clear takes priority over shifting in a newly accepted code
            if (clear)
                val <= '0;
            else if (accept)
                val <= {val[11:0], cur_code};
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4x4 switch-matrix model driving col.
module tb_keypad_scanner;

    logic        clk;
    logic        reset_n;
    logic [3:0]  col;
    logic [3:0]  row;
    logic        clear;
    logic [15:0] val;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;

    logic keys [4][4];
    int asserts  = 0;
    int failures = 0;
    int pulses   = 0;

    keypad_scanner #(.ROW_CYCLES(4), .DEBOUNCE_SCANS(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .col       (col),
        .row       (row),
        .clear     (clear),
        .val       (val),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A closed switch at (r,c) pulls col[c] low while row[r] is driven low.
    always_comb begin
        col = 4'hF;
        for (int unsigned rr = 0; rr < 4; rr++)
            for (int unsigned cc = 0; cc < 4; cc++)
                if (keys[rr][cc] && !row[rr]) col[cc] = 1'b0;
    end

    always @(posedge clk) if (key_valid === 1'b1) pulses <= pulses + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic open_all();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) keys[i][j] = 1'b0;
    endtask

    // Returns at the negedge inside the first cycle of a new scan (row 0).
    task automatic align();
        logic [3:0] prev;
        int guard;
        guard = 0;
        do begin
            prev = row;
            @(negedge clk);
            guard++;
        end while (!(row == 4'b1110 && prev == 4'b0111) && guard < 200);
        if (guard >= 200) begin
            asserts++;
            failures++;
            $display("FAIL align: row=%b never wrapped to 1110 within 200 cycles", row);
        end
    endtask

    task automatic press_release(input int r, input int c);
        align();
        keys[r][c] = 1'b1;
        tick(64);
        keys[r][c] = 1'b0;
        tick(48);
    endtask

    task automatic test_reset();
        int p0;
        reset_n = 1'b0;
        clear   = 1'b0;
        open_all();
        tick(2);
        asserts++; if (row !== 4'b1110) begin failures++; $display("FAIL reset_row: got %b expected 1110", row); end
        asserts++; if (val !== 16'h0000) begin failures++; $display("FAIL reset_val: got %h expected 0000", val); end
        asserts++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        asserts++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held: got %b expected 0", key_held); end
        asserts++; if (key_code !== 4'h0) begin failures++; $display("FAIL reset_code: got %h expected 0", key_code); end
        reset_n = 1'b1;
        tick(3);
        asserts++; if (row !== 4'b1110) begin failures++; $display("FAIL row0_hold: got %b expected 1110", row); end
        tick(1);
        asserts++; if (row !== 4'b1101) begin failures++; $display("FAIL row1_step: got %b expected 1101", row); end
        align();
        keys[1][2] = 1'b1;
        tick(20);
        #2 reset_n = 1'b0;
        #1;
        asserts++; if (row !== 4'b1110) begin failures++; $display("FAIL async_row: got %b expected 1110", row); end
        asserts++; if (key_held !== 1'b0) begin failures++; $display("FAIL async_held: got %b expected 0", key_held); end
        open_all();
        @(negedge clk);
        reset_n = 1'b1;
        p0 = pulses;
        align();
        keys[1][2] = 1'b1;
        tick(16);
        keys[1][2] = 1'b0;
        tick(48);
        asserts++; if (pulses - p0 !== 0) begin failures++; $display("FAIL discard_cand: got %0d pulses expected 0", pulses - p0); end
    endtask

    task automatic test_single_press();
        int p0;
        p0 = pulses;
        align();
        keys[1][2] = 1'b1;
        tick(32);
        asserts++; if (key_valid !== 1'b1) begin failures++; $display("FAIL press_valid: got %b expected 1", key_valid); end
        asserts++; if (key_code !== 4'h6) begin failures++; $display("FAIL press_code: got %h expected 6", key_code); end
        asserts++; if (val !== 16'h0006) begin failures++; $display("FAIL press_val: got %h expected 0006", val); end
        asserts++; if (key_held !== 1'b1) begin failures++; $display("FAIL press_held: got %b expected 1", key_held); end
        tick(1);
        asserts++; if (key_valid !== 1'b0) begin failures++; $display("FAIL pulse_width: got %b expected 0", key_valid); end
        tick(31);
        keys[1][2] = 1'b0;
        tick(16);
        asserts++; if (key_held !== 1'b1) begin failures++; $display("FAIL held_1scan: got %b expected 1", key_held); end
        tick(16);
        asserts++; if (key_held !== 1'b0) begin failures++; $display("FAIL held_2scan: got %b expected 0", key_held); end
        asserts++; if (pulses - p0 !== 1) begin failures++; $display("FAIL press_pulses: got %0d expected 1", pulses - p0); end
    endtask

    task automatic test_bounce();
        int p0;
        p0 = pulses;
        align();
        keys[0][1] = 1'b1;
        tick(16);
        keys[0][1] = 1'b0;
        tick(48);
        asserts++; if (pulses - p0 !== 0) begin failures++; $display("FAIL bounce_pulses: got %0d expected 0", pulses - p0); end
        asserts++; if (val !== 16'h0006) begin failures++; $display("FAIL bounce_val: got %h expected 0006", val); end
        asserts++; if (key_held !== 1'b0) begin failures++; $display("FAIL bounce_held: got %b expected 0", key_held); end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulses;
        press_release(0, 1);
        press_release(0, 2);
        press_release(0, 3);
        press_release(1, 0);
        asserts++; if (pulses - p0 !== 4) begin failures++; $display("FAIL seq_pulses: got %0d expected 4", pulses - p0); end
        asserts++; if (val !== 16'h1234) begin failures++; $display("FAIL seq_val: got %h expected 1234", val); end
        press_release(3, 3);
        asserts++; if (val !== 16'h234F) begin failures++; $display("FAIL seq_val5: got %h expected 234f", val); end
        asserts++; if (key_code !== 4'hF) begin failures++; $display("FAIL seq_code5: got %h expected f", key_code); end
        asserts++; if (pulses - p0 !== 5) begin failures++; $display("FAIL seq_pulses5: got %0d expected 5", pulses - p0); end
    endtask

    task automatic test_multi();
        int p0;
        p0 = pulses;
        align();
        keys[0][0] = 1'b1;
        keys[2][1] = 1'b1;
        tick(64);
        asserts++; if (pulses - p0 !== 0) begin failures++; $display("FAIL multi_pulses: got %0d expected 0", pulses - p0); end
        asserts++; if (key_held !== 1'b0) begin failures++; $display("FAIL multi_held: got %b expected 0", key_held); end
        open_all();
        tick(32);
        align();
        keys[1][1] = 1'b1;
        tick(32);
        asserts++; if (key_valid !== 1'b1) begin failures++; $display("FAIL key5_valid: got %b expected 1", key_valid); end
        asserts++; if (key_code !== 4'h5) begin failures++; $display("FAIL key5_code: got %h expected 5", key_code); end
        keys[2][2] = 1'b1;
        tick(32);
        asserts++; if (key_held !== 1'b1) begin failures++; $display("FAIL second_held: got %b expected 1", key_held); end
        asserts++; if (pulses - p0 !== 1) begin failures++; $display("FAIL second_pulses: got %0d expected 1", pulses - p0); end
        open_all();
        tick(48);
        asserts++; if (key_held !== 1'b0) begin failures++; $display("FAIL second_release: got %b expected 0", key_held); end
        asserts++; if (val !== 16'h34F5) begin failures++; $display("FAIL multi_val: got %h expected 34f5", val); end
    endtask

    task automatic test_clear();
        @(negedge clk);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        asserts++; if (val !== 16'h0000) begin failures++; $display("FAIL clear_val: got %h expected 0000", val); end
        asserts++; if (key_code !== 4'h5) begin failures++; $display("FAIL clear_code: got %h expected 5", key_code); end
        press_release(0, 1);
        press_release(0, 2);
        press_release(0, 3);
        press_release(1, 0);
        asserts++; if (val !== 16'h1234) begin failures++; $display("FAIL reload_val: got %h expected 1234", val); end
        align();
        keys[1][3] = 1'b1;
        tick(31);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        asserts++; if (key_valid !== 1'b1) begin failures++; $display("FAIL clracc_valid: got %b expected 1", key_valid); end
        asserts++; if (val !== 16'h0000) begin failures++; $display("FAIL clracc_val: got %h expected 0000", val); end
        asserts++; if (key_code !== 4'h7) begin failures++; $display("FAIL clracc_code: got %h expected 7", key_code); end
        tick(1);
        asserts++; if (key_valid !== 1'b0) begin failures++; $display("FAIL clracc_width: got %b expected 0", key_valid); end
        tick(5);
        #2 reset_n = 1'b0;
        #1;
        asserts++; if (key_held !== 1'b0) begin failures++; $display("FAIL rst_held: got %b expected 0", key_held); end
        asserts++; if (val !== 16'h0000) begin failures++; $display("FAIL rst_val: got %h expected 0000", val); end
        asserts++; if (row !== 4'b1110) begin failures++; $display("FAIL rst_row: got %b expected 1110", row); end
        open_all();
        @(negedge clk);
        reset_n = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_back_to_back();
        test_multi();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
